// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared definitions for the multi-port register file:
//   rf_state_t   : sweep/operate state of the register file core
//   DEF_XLEN     : default data word width
//   DEF_NREGS    : default number of architectural registers
//   DEF_NRD      : default number of read ports
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-producer (busy) vector for the register file.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears all busy bits)
//   i_en         : block is operating; rd_busy forced low otherwise
//   i_set_en     : qualified allocation this cycle
//   i_set_addr   : register being allocated
//   i_clr_en     : qualified write this cycle
//   i_clr_addr   : register being written
//   i_rd_addr    : packed read addresses, port k at [k*AW +: AW]
//   o_rd_busy    : per read port busy flag
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clear is applied before set so that an allocation landing on the same
    // register as the retiring write leaves the new producer pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A write to the addressed register this cycle delivers its value through
    // the bypass, so the reader need not wait for it.
    always_comb begin
        o_rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            o_rd_busy[k] = i_en
                         && r_busy[i_rd_addr[k*AW +: AW]]
                         && !(i_clr_en && (i_clr_addr == i_rd_addr[k*AW +: AW]));
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file with write bypass, hard-wired zero register,
// a pending-producer scoreboard, and a post-reset sweep that zeroes storage.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   ready       : sweep finished; writes and allocations are accepted
//   rd_addr     : packed read addresses, port k at [k*AW +: AW]
//   rd_data     : packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy     : per read port, addressed register has a pending producer
//   we, wr_addr, wr_data : write port
//   alloc_en, alloc_addr : mark a register as pending
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr
);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    // One extra bit so the sweep counter can never wrap back to zero.
    logic [AW:0]     r_idx;
    logic [AW:0]     w_idx_nxt;
    logic [XLEN-1:0] r_mem [NREGS];

    logic w_run;
    logic w_wr_q;
    logic w_alloc_q;
    logic w_init_last;

    assign w_run       = (r_state == RUN);
    assign ready       = w_run;
    assign w_wr_q      = w_run && we && (wr_addr != '0);
    assign w_alloc_q   = w_run && alloc_en && (alloc_addr != '0);
    assign w_init_last = (r_idx == (AW+1)'(NREGS-1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            INIT: begin
                w_idx_nxt = r_idx + 1'b1;
                if (w_init_last) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Storage is never touched by reset itself; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_idx[AW-1:0]] <= '0;
            end else if (w_wr_q) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (w_run && (rd_addr[k*AW +: AW] != '0)) begin
                if (w_wr_q && (wr_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[k*XLEN +: XLEN] = r_mem[rd_addr[k*AW +: AW]];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_run),
        .i_set_en   (w_alloc_q),
        .i_set_addr (alloc_addr),
        .i_clr_en   (w_wr_q),
        .i_clr_addr (wr_addr),
        .i_rd_addr  (rd_addr),
        .o_rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed, self-checking bench for regfile_mp (XLEN=32, NREGS=32, NRD=2).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;

    int n_vec;
    int n_err;
    int cnt;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready rises, bounded.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (!ready && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        we         = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        rd_addr    = '0;

        // Reset for two cycles, then release and count the sweep.
        tick();
        tick();
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_busy", {62'd0, rd_busy}, 64'd0);
        rst        = 1'b0;
        // Writes and allocs during the sweep must be ignored.
        we         = 1'b1;
        wr_addr    = 5'd12;
        wr_data    = 32'h0000_0777;
        alloc_en   = 1'b1;
        alloc_addr = 5'd12;
        rd_addr    = {5'd12, 5'd12};
        #1;
        chk("init_rdata", rd_data, 64'd0);
        chk("init_busy", {62'd0, rd_busy}, 64'd0);
        wait_ready(cnt);
        we       = 1'b0;
        alloc_en = 1'b0;
        #1;
        chk("init_len", 64'(cnt), 64'd32);
        chk("init_wr_ignored", rd_data, 64'd0);
        chk("init_alloc_ignored", {62'd0, rd_busy}, 64'd0);
        rd_addr = {5'd31, 5'd5};
        #1;
        chk("swept_zero", rd_data, 64'd0);

        // Write with same-cycle bypass, then plain read.
        we      = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEAD_BEEF;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("bypass", rd_data, 64'h0000_0000_DEAD_BEEF);
        tick();
        we = 1'b0;
        #1;
        chk("stored", rd_data, 64'h0000_0000_DEAD_BEEF);

        // Register 0 guard.
        we         = 1'b1;
        wr_addr    = 5'd0;
        wr_data    = 32'hFFFF_FFFF;
        alloc_en   = 1'b1;
        alloc_addr = 5'd0;
        rd_addr    = {5'd0, 5'd0};
        #1;
        chk("x0_bypass", rd_data, 64'd0);
        chk("x0_busy_now", {62'd0, rd_busy}, 64'd0);
        tick();
        we       = 1'b0;
        alloc_en = 1'b0;
        #1;
        chk("x0_data", rd_data, 64'd0);
        chk("x0_busy", {62'd0, rd_busy}, 64'd0);

        // Scoreboard set / clear / same-cycle priority.
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        rd_addr    = {5'd7, 5'd7};
        #1;
        chk("alloc_not_yet", {62'd0, rd_busy}, 64'd0);
        tick();
        alloc_en = 1'b0;
        #1;
        chk("alloc_busy", {62'd0, rd_busy}, 64'd3);
        we      = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h0000_0012;
        #1;
        chk("wr_mask_busy", {62'd0, rd_busy}, 64'd0);
        chk("wr7_bypass", rd_data, 64'h0000_0012_0000_0012);
        tick();
        we = 1'b0;
        #1;
        chk("wr_cleared", {62'd0, rd_busy}, 64'd0);
        chk("wr7_stored", rd_data, 64'h0000_0012_0000_0012);
        we         = 1'b1;
        wr_data    = 32'h0000_0034;
        alloc_en   = 1'b1;
        alloc_addr = 5'd7;
        #1;
        chk("both_masked", {62'd0, rd_busy}, 64'd0);
        tick();
        we       = 1'b0;
        alloc_en = 1'b0;
        #1;
        chk("both_busy_wins", {62'd0, rd_busy}, 64'd3);
        chk("both_data", rd_data, 64'h0000_0034_0000_0034);

        // Two ports on the same address.
        we      = 1'b1;
        wr_addr = 5'd12;
        wr_data = 32'h0000_A5A5;
        tick();
        we      = 1'b0;
        rd_addr = {5'd12, 5'd12};
        #1;
        chk("dual_same", rd_data, 64'h0000_A5A5_0000_A5A5);

        // Mid-run reset.
        we      = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h0000_0055;
        tick();
        we         = 1'b0;
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        tick();
        alloc_en = 1'b0;
        rd_addr  = {5'd9, 5'd3};
        #1;
        chk("pre_rst_data", rd_data[31:0], 64'h55);
        chk("pre_rst_busy", {62'd0, rd_busy}, 64'd2);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        we         = 1'b1;
        wr_addr    = 5'd3;
        wr_data    = 32'h0000_0099;
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        #1;
        chk("mid_rst_ready", {63'd0, ready}, 64'd0);
        chk("mid_rst_busy", {62'd0, rd_busy}, 64'd0);
        wait_ready(cnt);
        we       = 1'b0;
        alloc_en = 1'b0;
        #1;
        chk("mid_init_len", 64'(cnt), 64'd32);
        chk("mid_swept", rd_data, 64'd0);
        chk("mid_busy_clear", {62'd0, rd_busy}, 64'd0);

        // Held reset makes no sweep progress.
        rst = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b0;
        wait_ready(cnt);
        chk("held_rst_len", 64'(cnt), 64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
